apb_timer_array: RTL

APB_TIMER_ARRAY -- requirements
Module: apb_timer_array

---
 rtl/apb_timer_array_if.sv | 26 ++
 rtl/apb_timer_array.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_array_if.sv
// APB3/APB4 slave bus bundle for the timer array; the master drives requests and
// the slave returns ready, read data and error.
interface apb_timer_array_if #(
    parameter int unsigned APB_AW = 12,
    parameter int unsigned APB_DW = 32
);
    logic [APB_AW-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [APB_DW-1:0]   pwdata;
    logic [APB_DW/8-1:0] pstrb;
    logic                pready;
    logic [APB_DW-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_timer_array.sv
// Array of CH_QTY up-counting timers with prescaler, compare, PWM output and a
// combined interrupt, programmed through a zero-wait-state APB slave.
module apb_timer_array #(
    parameter int unsigned APB_AW  = 12,
    parameter int unsigned APB_DW  = 32,
    parameter int unsigned CH_QTY  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic              pclk,
    input  logic              prst_n,
    apb_timer_array_if.slave  apb,
    input  logic [CH_QTY-1:0] ext_clk,
    output logic [CH_QTY-1:0] pwm,
    output logic              irq
);
    localparam int unsigned       StrbW     = APB_DW / 8;
    localparam logic [APB_AW-1:0] AddrLimit = APB_AW'(CH_QTY * 32);

    typedef enum logic [2:0] {
        RegCtrl, RegPresc, RegTop, RegCmp, RegCnt, RegStat, RegIe, RegRsvd
    } reg_e;

    logic [3:0]         ctrl_q  [CH_QTY];
    logic [3:0]         ctrl_d  [CH_QTY];
    logic [PRESC_W-1:0] presc_q [CH_QTY];
    logic [PRESC_W-1:0] presc_d [CH_QTY];
    logic [PRESC_W-1:0] psc_q   [CH_QTY];
    logic [PRESC_W-1:0] psc_d   [CH_QTY];
    logic [CNT_W-1:0]   top_q   [CH_QTY];
    logic [CNT_W-1:0]   top_d   [CH_QTY];
    logic [CNT_W-1:0]   cmp_q   [CH_QTY];
    logic [CNT_W-1:0]   cmp_d   [CH_QTY];
    logic [CNT_W-1:0]   cnt_q   [CH_QTY];
    logic [CNT_W-1:0]   cnt_d   [CH_QTY];
    logic [1:0]         stat_q  [CH_QTY];
    logic [1:0]         stat_d  [CH_QTY];
    logic [1:0]         ie_q    [CH_QTY];
    logic [1:0]         ie_d    [CH_QTY];

    logic [CH_QTY-1:0] ext_s1, ext_s2, ext_s3, ext_edge;
    logic [CH_QTY-1:0] pwm_q, pwm_d;

    logic              acc, addr_err, wr_en;
    logic [APB_AW-6:0] ch_field;
    reg_e              reg_sel;
    logic [APB_DW-1:0] wmask, rdata, wval;
    logic              base_tick, cnt_tick;
    logic [1:0]        stat_set, stat_clr;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              unused_addr;

    function automatic logic [APB_DW-1:0] merge(input logic [APB_DW-1:0] old,
                                                input logic [APB_DW-1:0] wdata,
                                                input logic [APB_DW-1:0] mask);
        return (old & ~mask) | (wdata & mask);
    endfunction

    assign acc         = apb.psel & apb.penable;
    assign ch_field    = apb.paddr[APB_AW-1:5];
    assign reg_sel     = reg_e'(apb.paddr[4:2]);
    assign addr_err    = (apb.paddr >= AddrLimit) || (reg_sel == RegRsvd);
    assign wr_en       = acc & apb.pwrite & ~addr_err;
    assign unused_addr = ^apb.paddr[1:0];
    assign ext_edge    = ext_s2 & ~ext_s3;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = acc & addr_err;
    assign apb.prdata  = (acc && !apb.pwrite && !addr_err) ? rdata : '0;
    assign pwm         = pwm_q;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < StrbW; b++) wmask[b*8 +: 8] = {8{apb.pstrb[b]}};
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CH_QTY; c++) begin
            if (ch_field == (APB_AW-5)'(c)) begin
                case (reg_sel)
                    RegCtrl:  rdata = APB_DW'(ctrl_q[c]);
                    RegPresc: rdata = APB_DW'(presc_q[c]);
                    RegTop:   rdata = APB_DW'(top_q[c]);
                    RegCmp:   rdata = APB_DW'(cmp_q[c]);
                    RegCnt:   rdata = APB_DW'(cnt_q[c]);
                    RegStat:  rdata = APB_DW'(stat_q[c]);
                    RegIe:    rdata = APB_DW'(ie_q[c]);
                    default:  rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        pwm_d     = '0;
        base_tick = 1'b0;
        cnt_tick  = 1'b0;
        stat_set  = '0;
        stat_clr  = '0;
        cnt_nxt   = '0;
        wval      = '0;
        for (int c = 0; c < CH_QTY; c++) begin
            ctrl_d[c]  = ctrl_q[c];
            presc_d[c] = presc_q[c];
            psc_d[c]   = psc_q[c];
            top_d[c]   = top_q[c];
            cmp_d[c]   = cmp_q[c];
            cnt_d[c]   = cnt_q[c];
            ie_d[c]    = ie_q[c];
            stat_set   = '0;
            stat_clr   = '0;
            cnt_tick   = 1'b0;
            base_tick  = ctrl_q[c][2] ? ext_edge[c] : 1'b1;

            if (!ctrl_q[c][0]) begin
                psc_d[c] = '0;
            end else if (base_tick) begin
                if (psc_q[c] == presc_q[c]) begin
                    psc_d[c] = '0;
                    cnt_tick = 1'b1;
                end else begin
                    psc_d[c] = psc_q[c] + PRESC_W'(1);
                end
            end

            // TOP below CNT never matches, so the counter rolls through 2^CNT_W-1 naturally.
            cnt_nxt = (cnt_q[c] == top_q[c]) ? '0 : cnt_q[c] + CNT_W'(1);
            if (cnt_tick) begin
                cnt_d[c] = cnt_nxt;
                if (cnt_q[c] == top_q[c]) begin
                    stat_set[0] = 1'b1;
                    if (ctrl_q[c][1]) ctrl_d[c][0] = 1'b0;
                end
                if (cnt_nxt == cmp_q[c]) stat_set[1] = 1'b1;
            end

            // Software writes land after the tick update so they take priority.
            if (wr_en && ch_field == (APB_AW-5)'(c)) begin
                case (reg_sel)
                    RegCtrl: begin
                        wval      = merge(APB_DW'(ctrl_q[c]), apb.pwdata, wmask);
                        ctrl_d[c] = wval[3:0];
                    end
                    RegPresc: begin
                        wval       = merge(APB_DW'(presc_q[c]), apb.pwdata, wmask);
                        presc_d[c] = wval[PRESC_W-1:0];
                    end
                    RegTop: begin
                        wval     = merge(APB_DW'(top_q[c]), apb.pwdata, wmask);
                        top_d[c] = wval[CNT_W-1:0];
                    end
                    RegCmp: begin
                        wval     = merge(APB_DW'(cmp_q[c]), apb.pwdata, wmask);
                        cmp_d[c] = wval[CNT_W-1:0];
                    end
                    RegCnt: begin
                        wval     = merge(APB_DW'(cnt_q[c]), apb.pwdata, wmask);
                        cnt_d[c] = wval[CNT_W-1:0];
                    end
                    RegStat: stat_clr = apb.pwdata[1:0] & {2{apb.pstrb[0]}};
                    RegIe: begin
                        wval    = merge(APB_DW'(ie_q[c]), apb.pwdata, wmask);
                        ie_d[c] = wval[1:0];
                    end
                    default: ;
                endcase
            end

            stat_d[c] = (stat_q[c] & ~stat_clr) | stat_set;
            pwm_d[c]  = ctrl_q[c][0] & ((cnt_q[c] < cmp_q[c]) ^ ctrl_q[c][3]);
        end
    end

    always_comb begin
        irq = 1'b0;
        for (int c = 0; c < CH_QTY; c++) irq = irq | (|(stat_q[c] & ie_q[c]));
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ext_s1 <= '0;
            ext_s2 <= '0;
            ext_s3 <= '0;
            pwm_q  <= '0;
            for (int c = 0; c < CH_QTY; c++) begin
                ctrl_q[c]  <= '0;
                presc_q[c] <= '0;
                psc_q[c]   <= '0;
                top_q[c]   <= '0;
                cmp_q[c]   <= '0;
                cnt_q[c]   <= '0;
                stat_q[c]  <= '0;
                ie_q[c]    <= '0;
            end
        end else begin
            ext_s1 <= ext_clk;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
            pwm_q  <= pwm_d;
            for (int c = 0; c < CH_QTY; c++) begin
                ctrl_q[c]  <= ctrl_d[c];
                presc_q[c] <= presc_d[c];
                psc_q[c]   <= psc_d[c];
                top_q[c]   <= top_d[c];
                cmp_q[c]   <= cmp_d[c];
                cnt_q[c]   <= cnt_d[c];
                stat_q[c]  <= stat_d[c];
                ie_q[c]    <= ie_d[c];
            end
        end
    end
endmodule
